// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider chain:
// default widths, standard timebase ratios and the half-period helper.
package clk_div_pkg;

  localparam int unsigned DIV_WIDTH = 10;

  localparam int unsigned DIV_US = 100;
  localparam int unsigned DIV_MS = 1000;
  localparam int unsigned DIV_S  = 1000;

  typedef enum logic [2:0] {
    ACT_HOLD    = 3'd0,
    ACT_COUNT   = 3'd1,
    ACT_WRAP    = 3'd2,
    ACT_RESTART = 3'd3,
    ACT_IDLE    = 3'd4
  } cnt_act_e;

  // Low phase length; an odd ratio puts the extra pulse in the low phase.
  function automatic logic [31:0] ceil_half(input logic [31:0] n);
    return (n >> 1) + {31'd0, n[0]};
  endfunction

endpackage

// File: rtl/clock_div_prog_edge_detector_rn.sv
// Registered rise/fall strobes of a level signal, asynchronous active-low reset.
module edge_detector_rn (
  input  logic clk,
  input  logic reset_n,
  input  logic sig,
  output logic p_edge,
  output logic n_edge
);

  logic r_sig_d;
  logic r_p_edge;
  logic r_n_edge;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sig_d  <= 1'b0;
      r_p_edge <= 1'b0;
      r_n_edge <= 1'b0;
    end else begin
      r_sig_d  <= sig;
      r_p_edge <= sig & ~r_sig_d;
      r_n_edge <= ~sig & r_sig_d;
    end
  end

  assign p_edge = r_p_edge;
  assign n_edge = r_n_edge;

endmodule

// File: rtl/clock_div_prog.sv
// Runtime-programmable divider: counts clk_source pulses, emits tick, a
// near-50% cp square wave and its edge strobes. Ratio 0 parks the stage.
module clock_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH        = DIV_WIDTH,
  parameter int unsigned DIV_RESET    = DIV_MS,
  parameter bit          LOAD_ON_WRAP = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_source,
  input  logic             clr,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic [WIDTH-1:0] div_active,
  output logic             tick,
  output logic             cp,
  output logic             p_edge,
  output logic             n_edge
);

  localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DIV_RESET);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div_active;
  logic [WIDTH-1:0] r_shadow;
  logic             r_pending;
  logic             r_tick;
  logic             r_cp;

  cnt_act_e         w_act;
  logic             w_last;
  logic             w_load_any;
  logic             w_apply;
  logic [WIDTH-1:0] w_new_div;
  logic [WIDTH-1:0] w_half;
  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0] w_shadow_next;
  logic             w_pending_next;
  logic             w_cp_next;
  logic             w_tick_next;

  // A load in the same cycle as a period boundary overrides the older shadow.
  always_comb begin
    w_load_any = div_load | r_pending;
    w_new_div  = div_load ? div_in : r_shadow;
    w_half     = WIDTH'(ceil_half(32'(r_div_active)));
    w_last     = (r_cnt >= (r_div_active - ONE));
  end

  always_comb begin
    w_act = ACT_HOLD;
    if (clr) begin
      w_act = ACT_RESTART;
    end else if (!LOAD_ON_WRAP && div_load) begin
      w_act = ACT_RESTART;
    end else if (r_div_active == '0) begin
      w_act = ACT_IDLE;
    end else if (clk_source) begin
      w_act = w_last ? ACT_WRAP : ACT_COUNT;
    end
  end

  always_comb begin
    w_cnt_next     = '0;
    w_apply        = 1'b0;
    w_cp_next      = 1'b0;
    w_tick_next    = 1'b0;
    w_div_next     = r_div_active;
    w_shadow_next  = r_shadow;
    w_pending_next = r_pending;

    unique case (w_act)
      ACT_HOLD:  w_cnt_next = r_cnt;
      ACT_COUNT: w_cnt_next = r_cnt + ONE;
      default:   w_cnt_next = '0;
    endcase

    if ((w_act == ACT_HOLD) || (w_act == ACT_COUNT)) begin
      w_cp_next = (w_cnt_next >= w_half);
    end

    w_tick_next = (w_act == ACT_WRAP);

    if ((w_act == ACT_WRAP) || (w_act == ACT_RESTART) || (w_act == ACT_IDLE)) begin
      w_apply = w_load_any;
    end

    if (w_apply) begin
      w_div_next     = w_new_div;
      w_shadow_next  = w_new_div;
      w_pending_next = 1'b0;
    end else if (div_load) begin
      w_shadow_next  = div_in;
      w_pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_div_active <= RESET_DIV;
      r_shadow     <= RESET_DIV;
      r_pending    <= 1'b0;
      r_tick       <= 1'b0;
      r_cp         <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_next;
      r_div_active <= w_div_next;
      r_shadow     <= w_shadow_next;
      r_pending    <= w_pending_next;
      r_tick       <= w_tick_next;
      r_cp         <= w_cp_next;
    end
  end

  edge_detector_rn u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .sig     (r_cp),
    .p_edge  (p_edge),
    .n_edge  (n_edge)
  );

  assign div_active = r_div_active;
  assign tick       = r_tick;
  assign cp         = r_cp;

endmodule

// File: tb/tb_clock_div_prog.sv
// Directed bench for clock_div_prog: one wrap-loading instance and one
// immediate-loading instance, expected values computed by hand per cycle.
module tb_clock_div_prog;

  localparam int W = 10;

  logic         clk;
  logic         reset_n;
  logic         clk_source;
  logic         clr;
  logic [W-1:0] div_in;
  logic         div_load;
  logic [W-1:0] div_active;
  logic         tick, cp, p_edge, n_edge;

  logic         s0, clr0, l0;
  logic [W-1:0] din0;
  logic [W-1:0] div0;
  logic         tick0, cp0, p0, n0;

  int checks = 0;
  int errors = 0;

  clock_div_prog #(.WIDTH(W), .DIV_RESET(1000), .LOAD_ON_WRAP(1'b1)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_source (clk_source),
    .clr        (clr),
    .div_in     (div_in),
    .div_load   (div_load),
    .div_active (div_active),
    .tick       (tick),
    .cp         (cp),
    .p_edge     (p_edge),
    .n_edge     (n_edge)
  );

  clock_div_prog #(.WIDTH(W), .DIV_RESET(1000), .LOAD_ON_WRAP(1'b0)) u_dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_source (s0),
    .clr        (clr0),
    .div_in     (din0),
    .div_load   (l0),
    .div_active (div0),
    .tick       (tick0),
    .cp         (cp0),
    .p_edge     (p0),
    .n_edge     (n0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until tick is seen; n = clocks taken, -1 if the budget ran out.
  task automatic wait_tick(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clk_source = 1'b0; clr = 1'b0; div_in = '0; div_load = 1'b0;
    s0 = 1'b0; clr0 = 1'b0; l0 = 1'b0; din0 = '0;
    step(); step();
    checks++; if (div_active !== 10'd1000) begin errors++; $display("FAIL reset div_active: got %0d want 1000", div_active); end
    checks++; if ({tick, cp, p_edge, n_edge} !== 4'b0000) begin errors++; $display("FAIL reset outputs: got %b want 0000", {tick, cp, p_edge, n_edge}); end
    checks++; if ({tick0, cp0, p0, n0} !== 4'b0000 || div0 !== 10'd1000) begin errors++; $display("FAIL reset dut0: got %b/%0d want 0000/1000", {tick0, cp0, p0, n0}, div0); end
  endtask

  task automatic test_default();
    int m;
    clk_source = 1'b1;
    reset_n = 1'b1;
    for (int k = 1; k <= 2100; k++) begin
      step();
      m = k % 1000;
      checks++; if (tick !== (m == 0)) begin errors++; $display("FAIL default tick k=%0d: got %b want %b", k, tick, (m == 0)); end
      checks++; if (cp !== (m >= 500)) begin errors++; $display("FAIL default cp k=%0d: got %b want %b", k, cp, (m >= 500)); end
      checks++; if (p_edge !== (m == 501)) begin errors++; $display("FAIL default p_edge k=%0d: got %b want %b", k, p_edge, (m == 501)); end
      checks++; if (n_edge !== (m == 1 && k > 1000)) begin errors++; $display("FAIL default n_edge k=%0d: got %b want %b", k, n_edge, (m == 1 && k > 1000)); end
    end
  endtask

  task automatic test_div5_sparse();
    int n, p;
    logic et, ec, ep, en;
    div_in = 10'd5; div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks++; if (div_active !== 10'd1000) begin errors++; $display("FAIL div5 early div_active: got %0d want 1000", div_active); end
    wait_tick(2000, n);
    checks++; if (n !== 899) begin errors++; $display("FAIL div5 wrap latency: got %0d want 899", n); end
    checks++; if (div_active !== 10'd5) begin errors++; $display("FAIL div5 div_active: got %0d want 5", div_active); end
    clk_source = 1'b0;
    step();
    checks++; if (n_edge !== 1'b1) begin errors++; $display("FAIL div5 n_edge after tick: got %b want 1", n_edge); end
    for (int j = 1; j <= 45; j++) begin
      clk_source = (j % 3 == 1);
      step();
      p  = (j + 2) / 3;
      et = (j % 3 == 1) && (p % 5 == 0);
      ec = (p % 5 >= 3);
      ep = (j % 3 == 2) && (p % 5 == 3);
      en = (j % 3 == 2) && (p % 5 == 0);
      checks++; if (tick !== et) begin errors++; $display("FAIL div5 tick j=%0d: got %b want %b", j, tick, et); end
      checks++; if (cp !== ec) begin errors++; $display("FAIL div5 cp j=%0d: got %b want %b", j, cp, ec); end
      checks++; if (p_edge !== ep) begin errors++; $display("FAIL div5 p_edge j=%0d: got %b want %b", j, p_edge, ep); end
      checks++; if (n_edge !== en) begin errors++; $display("FAIL div5 n_edge j=%0d: got %b want %b", j, n_edge, en); end
    end
    clk_source = 1'b0;
  endtask

  task automatic test_load_on_wrap();
    int n;
    div_in = 10'd1000; div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks++; if (div_active !== 10'd5) begin errors++; $display("FAIL low pending held: got %0d want 5", div_active); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (div_active !== 10'd1000) begin errors++; $display("FAIL low clr applies pending: got %0d want 1000", div_active); end
    checks++; if ({tick, cp} !== 2'b00) begin errors++; $display("FAIL low clr tick/cp: got %b want 00", {tick, cp}); end
    clk_source = 1'b1;
    for (int i = 0; i < 200; i++) step();
    div_in = 10'd10; div_load = 1'b1;
    step();
    div_load = 1'b0;
    wait_tick(2000, n);
    checks++; if (n !== 799) begin errors++; $display("FAIL low old period finish: got %0d want 799", n); end
    checks++; if (div_active !== 10'd10) begin errors++; $display("FAIL low div_active 10: got %0d want 10", div_active); end
    wait_tick(100, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL low period 10: got %0d want 10", n); end
    for (int i = 0; i < 9; i++) step();
    div_in = 10'd20; div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL low coincident tick: got %b want 1", tick); end
    checks++; if (div_active !== 10'd20) begin errors++; $display("FAIL low coincident div_active: got %0d want 20", div_active); end
    wait_tick(100, n);
    checks++; if (n !== 20) begin errors++; $display("FAIL low period 20: got %0d want 20", n); end
  endtask

  task automatic test_idle_and_n1();
    int n, bad;
    div_in = 10'd0; div_load = 1'b1;
    step();
    div_load = 1'b0;
    wait_tick(100, n);
    checks++; if (n !== 19) begin errors++; $display("FAIL idle wrap latency: got %0d want 19", n); end
    checks++; if (div_active !== 10'd0) begin errors++; $display("FAIL idle div_active: got %0d want 0", div_active); end
    step();
    checks++; if (n_edge !== 1'b1) begin errors++; $display("FAIL idle final n_edge: got %b want 1", n_edge); end
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if ({tick, cp, p_edge, n_edge} !== 4'b0000) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle quiet: got %0d active cycles want 0", bad); end
    div_in = 10'd1; div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks++; if (div_active !== 10'd1) begin errors++; $display("FAIL n1 immediate load: got %0d want 1", div_active); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL n1 load tick: got %b want 0", tick); end
    for (int i = 0; i < 8; i++) begin
      clk_source = (i % 2 == 0);
      step();
      checks++; if (tick !== (i % 2 == 0)) begin errors++; $display("FAIL n1 tick i=%0d: got %b want %b", i, tick, (i % 2 == 0)); end
      checks++; if (cp !== 1'b0) begin errors++; $display("FAIL n1 cp i=%0d: got %b want 0", i, cp); end
    end
  endtask

  task automatic test_clr();
    int n;
    clk_source = 1'b1; div_in = 10'd1000; div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks++; if (tick !== 1'b1 || div_active !== 10'd1000) begin errors++; $display("FAIL clr setup: got tick %b div %0d want 1/1000", tick, div_active); end
    for (int i = 0; i < 700; i++) step();
    checks++; if (cp !== 1'b1) begin errors++; $display("FAIL clr cp at 700: got %b want 1", cp); end
    clr = 1'b1;
    step();
    clr = 1'b0; clk_source = 1'b0;
    checks++; if (cp !== 1'b0) begin errors++; $display("FAIL clr cp: got %b want 0", cp); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL clr tick: got %b want 0", tick); end
    step();
    checks++; if (n_edge !== 1'b1) begin errors++; $display("FAIL clr n_edge: got %b want 1", n_edge); end
    checks++; if (p_edge !== 1'b0) begin errors++; $display("FAIL clr p_edge: got %b want 0", p_edge); end
    clk_source = 1'b1;
    wait_tick(2000, n);
    checks++; if (n !== 1000) begin errors++; $display("FAIL clr full period: got %0d want 1000", n); end
  endtask

  task automatic test_async_reset();
    int n;
    for (int i = 0; i < 600; i++) step();
    div_in = 10'd10; div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks++; if (cp !== 1'b1) begin errors++; $display("FAIL areset pre cp: got %b want 1", cp); end
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if ({tick, cp, p_edge, n_edge} !== 4'b0000) begin errors++; $display("FAIL areset outputs: got %b want 0000", {tick, cp, p_edge, n_edge}); end
    checks++; if (div_active !== 10'd1000) begin errors++; $display("FAIL areset div_active: got %0d want 1000", div_active); end
    step();
    reset_n = 1'b1;
    wait_tick(2000, n);
    checks++; if (n !== 1000) begin errors++; $display("FAIL areset pending discarded: got %0d want 1000", n); end
    checks++; if (div_active !== 10'd1000) begin errors++; $display("FAIL areset div after wrap: got %0d want 1000", div_active); end
    clk_source = 1'b0;
  endtask

  task automatic test_load_immediate();
    int n;
    s0 = 1'b1;
    for (int i = 0; i < 700; i++) step();
    checks++; if (cp0 !== 1'b1) begin errors++; $display("FAIL imm cp at 700: got %b want 1", cp0); end
    din0 = 10'd5; l0 = 1'b1;
    step();
    l0 = 1'b0;
    checks++; if (div0 !== 10'd5) begin errors++; $display("FAIL imm div_active: got %0d want 5", div0); end
    checks++; if ({tick0, cp0} !== 2'b00) begin errors++; $display("FAIL imm tick/cp: got %b want 00", {tick0, cp0}); end
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (tick0 === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL imm restart period: got %0d want 5", n); end
    s0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default();
    test_div5_sparse();
    test_load_on_wrap();
    test_idle_and_n1();
    test_clr();
    test_async_reset();
    test_load_immediate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
